// File: rtl/aes_pkg.sv
// aes_pkg: shared AES helpers (sbox, rot/sub word, rcon) and key-schedule FSM states
package aes_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_EMIT, ST_DONE} state_t;
  localparam logic [7:0] RCON [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  function automatic logic [7:0] rcon(input logic [3:0] r);
    return (r <= 4'd10) ? RCON[r] : 8'h00;
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      p = p ^ (b[i] ? x : 8'h00);
      x = xtime(x);
    end
    return p;
  endfunction
  // multiplicative inverse as a^254 (maps 0 to 0), then the affine transform
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] s, r;
    s = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction
  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction
endpackage

// File: rtl/aes_inv_key_expansion_if.sv
// aes_inv_key_expansion_if: start/key request plus round-key valid/ready stream
interface aes_inv_key_expansion_if;
  logic         start;
  logic [127:0] last_key;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         round_key_valid;
  logic         round_key_ready;
  logic         busy;
  logic         done;
  modport master (output start, last_key, round_key_ready, input round_key, round_idx, round_key_valid, busy, done);
  modport slave (input start, last_key, round_key_ready, output round_key, round_idx, round_key_valid, busy, done);
endinterface

// File: rtl/aes_inv_key_step.sv
// aes_inv_key_step: one backward AES-128 key-schedule step, round-r key to round-(r-1) key
module aes_inv_key_step
  import aes_pkg::*;
(
  input  logic [127:0] key_in,
  input  logic [3:0]   round,
  output logic [127:0] key_out
);
  logic [31:0] p1, p2, p3;
  assign p3 = key_in[31:0] ^ key_in[63:32];
  assign p2 = key_in[63:32] ^ key_in[95:64];
  assign p1 = key_in[95:64] ^ key_in[127:96];
  assign key_out = {key_in[127:96] ^ sub_word(rot_word(p3)) ^ {rcon(round), 24'h0}, p1, p2, p3};
endmodule

// File: rtl/aes_inv_key_expansion.sv
// aes_inv_key_expansion: reverse AES-128 key schedule emitting keys 10..0; AES_INV_KEYEXP_ZEROIZE_EN clears the key after the run
module aes_inv_key_expansion
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = 10
) (
  input logic clk,
  input logic reset,
  aes_inv_key_expansion_if.slave bus
);
  if (NUM_ROUNDS != 10) begin : g_bad_rounds
    $error("aes_inv_key_expansion supports only NUM_ROUNDS = 10");
  end
  state_t       state, state_n;
  logic [127:0] key_reg, key_prev;
  logic [3:0]   idx_reg;
  logic         accept;
  aes_inv_key_step u_step (.key_in(key_reg), .round(idx_reg), .key_out(key_prev));
  // next state and status outputs decoded purely from state, so valid never depends on ready
  always_comb begin
    accept = (state == ST_EMIT) && bus.round_key_ready;
    state_n = (state == ST_IDLE && bus.start) ? ST_EMIT :
              (accept && idx_reg == 4'd0)     ? ST_DONE :
              (state == ST_DONE)              ? ST_IDLE : state;
    bus.round_key_valid = (state == ST_EMIT);
    bus.busy = (state != ST_IDLE);
    bus.done = (state == ST_DONE);
    bus.round_key = key_reg;
    bus.round_idx = idx_reg;
  end
  // state, key and round registers; key steps backwards on each accepted non-final key
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      key_reg <= '0;
      idx_reg <= '0;
    end else begin
      state <= state_n;
      if (state == ST_IDLE && bus.start) begin
        key_reg <= bus.last_key;
        idx_reg <= 4'(NUM_ROUNDS);
      end else if (accept && idx_reg != 4'd0) begin
        key_reg <= key_prev;
        idx_reg <= idx_reg - 4'd1;
      end
`ifdef AES_INV_KEYEXP_ZEROIZE_EN
      else if (state == ST_DONE) key_reg <= '0;
`endif
    end
  end
endmodule

// File: tb/tb_aes_inv_key_expansion.sv
// tb_aes_inv_key_expansion: randomized and FIPS-197 checks of the reverse key schedule
module tb_aes_inv_key_expansion;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n_cmp = 0;
  int n_bad = 0;
  localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] FIPS_K9 = 128'hac7766f319fadc2128d12941575c006e;
  localparam logic [127:0] FIPS_K0 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  logic [127:0] exp_keys [0:10];
  logic [127:0] cap_key [0:10];
  logic [3:0]   cap_idx [0:10];
  int cap_n, cap_t;
  bit cap_stable, cap_timeout, cap_done;
  aes_inv_key_expansion_if bus ();
  aes_inv_key_expansion #(.NUM_ROUNDS(10)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'h11b << (i - 8));
    return p[7:0];
  endfunction
  function automatic logic [7:0] m_sbox(input logic [7:0] x);
    logic [7:0] inv, b;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) if (m_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
    for (int i = 0; i < 8; i++)
      b[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ ((8'h63 >> i) & 8'h01) != 0;
    return b;
  endfunction
  task automatic model(input logic [127:0] lk);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0] rc;
    for (int j = 0; j < 4; j++) w[40 + j] = lk[127 - 32 * j -: 32];
    for (int i = 43; i >= 4; i--) begin
      t = w[i - 1];
      if (i % 4 == 0) begin
        rc = 8'h01;
        for (int j = 1; j < i / 4; j++) rc = m_mul(rc, 8'h02);
        t = {m_sbox(t[23:16]) ^ rc, m_sbox(t[15:8]), m_sbox(t[7:0]), m_sbox(t[31:24])};
      end
      w[i - 4] = w[i] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_keys[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
  endtask
  task automatic capture(input logic [127:0] lk, input int stall_idx, input int stall_len, input int glitch_idx, input int stop_idx);
    int stalled;
    logic [127:0] held;
    stalled = 0;
    held = '0;
    cap_n = 0; cap_t = 0; cap_stable = 1; cap_timeout = 0; cap_done = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.last_key = lk;
    bus.round_key_ready = 1'b1;
    forever begin
      @(negedge clk);
      cap_t++;
      bus.start = 1'b0;
      bus.last_key = {$urandom, $urandom, $urandom, $urandom};
      if (bus.done) begin cap_done = 1; break; end
      if (cap_t > 100) begin cap_timeout = 1; break; end
      if (bus.round_key_valid) begin
        if (int'(bus.round_idx) == stop_idx) break;
        if (int'(bus.round_idx) == glitch_idx) begin
          bus.start = 1'b1;
          bus.last_key = ~lk;
        end
        if (int'(bus.round_idx) == stall_idx && stalled < stall_len) begin
          if (stalled == 0) held = bus.round_key;
          else if (bus.round_key !== held) cap_stable = 0;
          stalled++;
          bus.round_key_ready = 1'b0;
        end else begin
          bus.round_key_ready = 1'b1;
          if (cap_n < 11) begin
            cap_key[cap_n] = bus.round_key;
            cap_idx[cap_n] = bus.round_idx;
          end
          cap_n++;
        end
      end
    end
  endtask
  task automatic test_reset;
    n_cmp++; if (bus.round_key !== '0) begin n_bad++; $display("FAIL reset_key got %h want 0", bus.round_key); end
    n_cmp++; if (bus.round_idx !== 4'd0) begin n_bad++; $display("FAIL reset_idx got %0d want 0", bus.round_idx); end
    n_cmp++; if (bus.round_key_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", bus.round_key_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    n_cmp++; if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done got %b want 0", bus.done); end
  endtask
  task automatic test_fips;
    logic [127:0] after;
    model(FIPS_K10);
    capture(FIPS_K10, -1, 0, -1, -1);
    n_cmp++; if (!cap_done || cap_timeout || cap_n != 11) begin n_bad++; $display("FAIL fips_run got keys=%0d done=%b want keys=11 done=1", cap_n, cap_done); end
    n_cmp++; if (cap_t != 12) begin n_bad++; $display("FAIL fips_done_time got %0d want 12", cap_t); end
    n_cmp++; if (cap_key[0] !== FIPS_K10) begin n_bad++; $display("FAIL fips_k10 got %h want %h", cap_key[0], FIPS_K10); end
    n_cmp++; if (cap_key[1] !== FIPS_K9) begin n_bad++; $display("FAIL fips_k9 got %h want %h", cap_key[1], FIPS_K9); end
    n_cmp++; if (cap_key[10] !== FIPS_K0) begin n_bad++; $display("FAIL fips_k0 got %h want %h", cap_key[10], FIPS_K0); end
    for (int i = 0; i < 11; i++) begin
      n_cmp++; if (cap_idx[i] !== 4'(10 - i) || cap_key[i] !== exp_keys[10 - i]) begin n_bad++; $display("FAIL fips_seq[%0d] got %0d:%h want %0d:%h", i, cap_idx[i], cap_key[i], 10 - i, exp_keys[10 - i]); end
    end
    bus.start = 1'b1;
    bus.last_key = ~FIPS_K10;
    @(negedge clk);
    bus.start = 1'b0;
`ifdef AES_INV_KEYEXP_ZEROIZE_EN
    after = '0;
`else
    after = FIPS_K0;
`endif
    n_cmp++; if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_bad++; $display("FAIL done_start_ignored got busy=%b done=%b want 0 0", bus.busy, bus.done); end
    n_cmp++; if (bus.round_key !== after) begin n_bad++; $display("FAIL key_after_done got %h want %h", bus.round_key, after); end
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0 || bus.round_key !== after) begin n_bad++; $display("FAIL idle_hold got busy=%b key=%h want 0 %h", bus.busy, bus.round_key, after); end
  endtask
  task automatic test_backpressure;
    model(FIPS_K10);
    capture(FIPS_K10, 7, 5, -1, -1);
    n_cmp++; if (!cap_stable) begin n_bad++; $display("FAIL bp_stable got unstable key want stable"); end
    n_cmp++; if (!cap_done || cap_n != 11 || cap_t != 17) begin n_bad++; $display("FAIL bp_run got keys=%0d t=%0d want 11 17", cap_n, cap_t); end
    for (int i = 0; i < 11; i++) begin
      n_cmp++; if (cap_idx[i] !== 4'(10 - i) || cap_key[i] !== exp_keys[10 - i]) begin n_bad++; $display("FAIL bp_seq[%0d] got %0d:%h want %0d:%h", i, cap_idx[i], cap_key[i], 10 - i, exp_keys[10 - i]); end
    end
    n_cmp++; if (cap_key[10] !== FIPS_K0) begin n_bad++; $display("FAIL bp_k0 got %h want %h", cap_key[10], FIPS_K0); end
  endtask
  task automatic test_busy_start;
    model(FIPS_K10);
    capture(FIPS_K10, -1, 0, 5, -1);
    n_cmp++; if (!cap_done || cap_n != 11 || cap_t != 12) begin n_bad++; $display("FAIL busy_start_run got keys=%0d t=%0d want 11 12", cap_n, cap_t); end
    for (int i = 0; i < 11; i++) begin
      n_cmp++; if (cap_idx[i] !== 4'(10 - i) || cap_key[i] !== exp_keys[10 - i]) begin n_bad++; $display("FAIL busy_start_seq[%0d] got %0d:%h want %0d:%h", i, cap_idx[i], cap_key[i], 10 - i, exp_keys[10 - i]); end
    end
  endtask
  task automatic test_mid_reset;
    logic [127:0] lk;
    lk = {$urandom, $urandom, $urandom, $urandom};
    capture(lk, -1, 0, -1, 4);
    n_cmp++; if (bus.round_idx !== 4'd4 || cap_timeout) begin n_bad++; $display("FAIL mid_reset_reach got idx=%0d want 4", bus.round_idx); end
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.round_key_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin n_bad++; $display("FAIL mid_reset_ctrl got v=%b b=%b d=%b want 0 0 0", bus.round_key_valid, bus.busy, bus.done); end
    n_cmp++; if (bus.round_key !== '0 || bus.round_idx !== 4'd0) begin n_bad++; $display("FAIL mid_reset_data got %0d:%h want 0:0", bus.round_idx, bus.round_key); end
    @(negedge clk);
    n_cmp++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin n_bad++; $display("FAIL mid_reset_hold got b=%b d=%b want 0 0", bus.busy, bus.done); end
    reset = 1'b0;
    lk = {$urandom, $urandom, $urandom, $urandom};
    model(lk);
    capture(lk, -1, 0, -1, -1);
    n_cmp++; if (!cap_done || cap_n != 11 || cap_t != 12) begin n_bad++; $display("FAIL post_reset_run got keys=%0d t=%0d want 11 12", cap_n, cap_t); end
    n_cmp++; if (cap_key[0] !== lk) begin n_bad++; $display("FAIL post_reset_k10 got %h want %h", cap_key[0], lk); end
    for (int i = 0; i < 11; i++) begin
      n_cmp++; if (cap_idx[i] !== 4'(10 - i) || cap_key[i] !== exp_keys[10 - i]) begin n_bad++; $display("FAIL post_reset_seq[%0d] got %0d:%h want %0d:%h", i, cap_idx[i], cap_key[i], 10 - i, exp_keys[10 - i]); end
    end
  endtask
  task automatic test_random;
    logic [127:0] lk;
    int si, sl;
    for (int r = 0; r < 5; r++) begin
      lk = (r == 0) ? '0 : {$urandom, $urandom, $urandom, $urandom};
      si = $urandom_range(0, 10);
      sl = (r == 0) ? 0 : $urandom_range(1, 4);
      model(lk);
      capture(lk, si, sl, -1, -1);
      n_cmp++; if (!cap_done || cap_n != 11 || !cap_stable || cap_t != 12 + sl) begin n_bad++; $display("FAIL rand%0d_run got keys=%0d t=%0d stable=%b want 11 %0d 1", r, cap_n, cap_t, cap_stable, 12 + sl); end
      for (int i = 0; i < 11; i++) begin
        n_cmp++; if (cap_idx[i] !== 4'(10 - i) || cap_key[i] !== exp_keys[10 - i]) begin n_bad++; $display("FAIL rand%0d_seq[%0d] got %0d:%h want %0d:%h", r, i, cap_idx[i], cap_key[i], 10 - i, exp_keys[10 - i]); end
      end
    end
  endtask
  initial begin
    bus.start = 1'b0;
    bus.last_key = '0;
    bus.round_key_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset;
    reset = 1'b0;
    @(negedge clk);
    test_reset;
    test_fips;
    test_backpressure;
    test_busy_start;
    test_mid_reset;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
